// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART receiver.
// Line format is fixed 8N1; only the clocking is parameterised.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   // Clock cycles per oversample tick, rounded to nearest and never zero.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      longint rate;
      longint div;
      rate = longint'(baud) * longint'(os);
      div  = (longint'(clk_hz) + rate / 2) / rate;
      if (div < 1) div = 1;
      return int'(div);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer cell for a single asynchronous level.
// Both stages reset to RST_VAL so the output is defined out of reset.
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta <= RST_VAL;
         q_o  <= RST_VAL;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick_o pulse every DIV clocks.
// clr_i holds the phase at zero so the first tick lines up with a start edge.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (clr_i || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick_o = !clr_i && (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: oversampled, 3-sample majority vote per bit, valid/ready
// output register, one-cycle framing and overrun error pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD        = 256_000,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int IW  = $clog2(DATA_BITS);

   logic rx_s;
   logic tick;

   state_t               state, state_next;
   logic [SW-1:0]        s_cnt, s_next;
   logic [IW-1:0]        idx, idx_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic                 v0, v0_next;
   logic                 v1, v1_next;

   logic maj;
   logic vote;
   logic last_s;
   logic deliver;
   logic ferr;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (rx_i),
      .q_o    (rx_s)
   );

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (state == IDLE),
      .tick_o (tick)
   );

   // The third sample is taken live on the deciding tick.
   assign maj    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
   assign vote   = tick && (s_cnt == SW'(M + 1));
   assign last_s = tick && (s_cnt == SW'(OVERSAMPLE - 1));
   assign busy_o = (state != IDLE);

   always_comb begin
      state_next = state;
      s_next     = s_cnt;
      idx_next   = idx;
      shift_next = shift;
      v0_next    = v0;
      v1_next    = v1;
      deliver    = 1'b0;
      ferr       = 1'b0;

      if (tick && (state == START || state == DATA || state == STOP)) begin
         s_next = (s_cnt == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt + SW'(1);
         if (s_cnt == SW'(M - 1)) v0_next = rx_s;
         if (s_cnt == SW'(M))     v1_next = rx_s;
      end

      unique case (state)
         IDLE: begin
            if (en_i && !rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            if (vote && maj) begin
               state_next = IDLE;
            end else if (last_s) begin
               state_next = DATA;
               idx_next   = '0;
            end
         end
         DATA: begin
            if (vote) shift_next[idx] = maj;
            if (last_s) begin
               if (idx == IW'(DATA_BITS - 1)) state_next = STOP;
               else                           idx_next   = idx + IW'(1);
            end
         end
         STOP: begin
            // Leave on the vote itself so the next start edge is not missed.
            if (vote) begin
               if (maj) begin
                  deliver    = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr       = 1'b1;
                  state_next = BRK;
               end
            end
         end
         BRK: begin
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (!en_i) begin
         state_next = IDLE;
         deliver    = 1'b0;
         ferr       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         s_cnt <= '0;
         idx   <= '0;
         shift <= '0;
         v0    <= 1'b1;
         v1    <= 1'b1;
      end else begin
         state <= state_next;
         s_cnt <= s_next;
         idx   <= idx_next;
         shift <= shift_next;
         v0    <= v0_next;
         v1    <= v1_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= ferr;
         overrun_o   <= deliver && valid_o && !ready_i;
         if (deliver && (!valid_o || ready_i)) begin
            data_o  <= shift;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus random frames, checked
// against a transaction-level model of the output register and error pulses.
`timescale 1ns/1ps
module tb_uart_rx_core;

   localparam int BIT_CYC = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       rx_line = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   uart_rx_core #(
      .CLK_FREQ_HZ (1_600_000),
      .BAUD        (100_000),
      .OVERSAMPLE  (16)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .rx_i        (rx_line),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // observed side
   logic [7:0] got_q[$];
   int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, long_cnt = 0, unstable_cnt = 0;
   int t_valid = 0, t_start = 0;
   bit saw_busy = 0;
   logic valid_prev = 0, ferr_prev = 0, ovr_prev = 0, acc_prev = 0;
   logic [7:0] data_prev = 0;

   // model side
   logic [7:0] exp_q[$];
   int   exp_ferr = 0, exp_ovr = 0;
   logic exp_valid = 0;
   logic [7:0] exp_data = 0;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         valid_prev = 0; ferr_prev = 0; ovr_prev = 0; acc_prev = 0;
      end else begin
         if (frame_err_o) ferr_cnt++;
         if (overrun_o) ovr_cnt++;
         if (frame_err_o && overrun_o) both_cnt++;
         if ((frame_err_o && ferr_prev) || (overrun_o && ovr_prev)) long_cnt++;
         if (valid_o && !valid_prev) t_valid = cyc;
         if (valid_prev && valid_o && !acc_prev && data_o != data_prev) unstable_cnt++;
         if (valid_o && ready) got_q.push_back(data_o);
         if (busy_o) saw_busy = 1;
         valid_prev = valid_o; ferr_prev = frame_err_o; ovr_prev = overrun_o;
         acc_prev = valid_o && ready; data_prev = data_o;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ready changes go through here so the model sees a pending byte consumed.
   task automatic set_ready(input logic v);
      ready = v;
      if (v && exp_valid) begin
         exp_q.push_back(exp_data);
         exp_valid = 0;
      end
   endtask

   task automatic exp_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) exp_ferr++;
      else if (ready) begin
         exp_q.push_back(b);
         exp_data = b;
      end else if (exp_valid) exp_ovr++;
      else begin
         exp_valid = 1;
         exp_data = b;
      end
   endtask

   task automatic exp_reset();
      exp_valid = 0;
      exp_data = 0;
   endtask

   task automatic drive_cell(input logic v, input bit spike);
      for (int j = 0; j < BIT_CYC; j++) begin
         rx_line = (spike && j == 9) ? ~v : v;
         step(1);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit spike);
      $display("frame byte=0x%02h stop=%0d spike=%0d ready=%0d en=%0d", b, stop_v, spike, ready, en);
      t_start = cyc;
      drive_cell(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_cell(b[i], spike);
      drive_cell(stop_v, 1'b0);
      rx_line = 1'b1;
   endtask

   task automatic check_model(input string tag);
      int n;
      @(negedge clk);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
      check({tag, "_ferr"}, ferr_cnt, exp_ferr);
      check({tag, "_ovr"}, ovr_cnt, exp_ovr);
      check({tag, "_valid"}, valid_o, exp_valid);
      check({tag, "_data"}, data_o, exp_data);
      check({tag, "_pulse"}, both_cnt + long_cnt + unstable_cnt, 0);
      got_q.delete();
      exp_q.delete();
      step(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_data"}, data_o, 0);
      check({tag, "_valid"}, valid_o, 0);
      check({tag, "_ferr"}, frame_err_o, 0);
      check({tag, "_ovr"}, overrun_o, 0);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, settle;
      logic [7:0] b;
      bit ok;

      // reset values
      step(2);
      check_reset_outputs("reset");
      step(1);
      rst_n = 1;
      step(4);

      // A: plain byte with latency and single-cycle valid
      set_ready(1);
      send_frame(8'hA5, 1'b1, 1'b0);
      exp_frame(8'hA5, 1);
      step(4);
      lat = t_valid - t_start;
      check("a5_latency_window", (lat >= 154 && lat <= 158), 1);
      check_model("a5");

      // B: short glitch must be rejected as a false start
      saw_busy = 0;
      settle = -1;
      rx_line = 0;
      step(4);
      rx_line = 1;
      for (int i = 5; i < 24 && settle < 0; i++) begin
         @(negedge clk);
         if (saw_busy && !busy_o) settle = i;
         step(1);
      end
      check("glitch_saw_busy", saw_busy, 1);
      check("glitch_settle", (settle > 0 && settle <= 14), 1);
      check_model("glitch");

      // C: framing error, held break, then recovery
      send_frame(8'h3C, 1'b0, 1'b0);
      exp_frame(8'h3C, 0);
      rx_line = 0;
      step(64);
      @(negedge clk);
      check("brk_busy_held", busy_o, 1);
      step(1);
      rx_line = 1;
      step(6);
      @(negedge clk);
      check("brk_busy_released", busy_o, 0);
      step(1);
      check_model("ferr");
      send_frame(8'h81, 1'b1, 1'b0);
      exp_frame(8'h81, 1);
      step(4);
      check_model("after_brk");

      // D: overrun with ready low, then one accept cycle
      set_ready(0);
      send_frame(8'h11, 1'b1, 1'b0);
      exp_frame(8'h11, 1);
      send_frame(8'h22, 1'b1, 1'b0);
      exp_frame(8'h22, 1);
      step(4);
      check_model("overrun");
      set_ready(1);
      step(1);
      set_ready(0);
      @(negedge clk);
      check("ovr_valid_cleared", valid_o, 0);
      step(1);
      check_model("ovr_drain");

      // E: reset during data bit 3
      set_ready(1);
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            step(BIT_CYC * 4 + 8);
            rst_n = 0;
            exp_reset();
            check_reset_outputs("midreset");
            step(3);
            rst_n = 1;
         end
      join
      step(6);
      check_model("post_reset");
      send_frame(8'h7E, 1'b1, 1'b0);
      exp_frame(8'h7E, 1);
      step(4);
      check_model("after_reset");

      // F: spiked bits survive the vote; disabled frame is silent
      send_frame(8'h55, 1'b1, 1'b1);
      exp_frame(8'h55, 1);
      step(4);
      fork
         send_frame(8'h0F, 1'b1, 1'b0);
         begin
            step(BIT_CYC * 3);
            en = 0;
         end
      join
      step(4);
      en = 1;
      step(4);
      check_model("spike_abort");

      // G: random frames, random ready, occasional bad stop bit
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         set_ready(logic'($urandom_range(0, 1)));
         send_frame(b, ok, 1'b0);
         exp_frame(b, ok);
         step($urandom_range(4, 10));
      end
      set_ready(1);
      step(4);
      check_model("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
